lsu_split: RTL and testbench

Load/store unit for the pipelined RV32I core, replacing the single-cycle, fixed-latency data-memory access in the memory stage. It accepts one load or store per handshake from execute and issues word-aligned, byte-enabled transactions to a data memory of arbitrary latency over a valid/ready interface. It returns sign- or zero-extended load data, or a store acknowledge, to writeback. Misaligned accesses are optionally split into two aligned transactions.

---
 rtl/lsu_pkg.sv | 69 ++++++
 rtl/lsu_split_if.sv | 49 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_split.sv | 193 +++++++++++++++++++
 tb/tb_lsu_split.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the split-capable load/store unit.
//   lsu_state_e   : FSM state encoding used by lsu_split
//   F3_*          : RV32I load/store funct3 codes
//   SIZE_*        : access size taken from funct3[1:0]
//   be_mask       : byte-enable mask for an access size, before lane shifting
//   is_illegal    : funct3 that names no RV32I load/store
//   is_misaligned : access whose bytes cross a word boundary
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Unshifted byte-enable mask; size 3 never reaches memory (it is illegal)
  function automatic logic [3:0] be_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
    if (store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: return 1'b0;
        default:             return 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b0;
        default:                             return 1'b1;
      endcase
    end
  endfunction

  // offset + bytes > 4
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset == 2'd3;
      SIZE_WORD: return offset != 2'd0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_split_if.sv
// ---------------------------------------------------------------------------
// lsu_split_if
// Bundles the execute-side request, writeback-side response and data-memory
// bus of the load/store unit.
//   slave  : the LSU's view (takes requests, drives responses and memory reqs)
//   master : the environment's view (execute, writeback and data memory)
// Parameter ADDR_W : byte-address width.
// ---------------------------------------------------------------------------
interface lsu_split_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              rsp_valid;
  logic [4:0]        rsp_rd;
  logic [31:0]       rsp_data;
  logic              rsp_fault;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_fault,
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_fault,
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   offset_i    : byte offset addr[1:0] of the access
//   funct3_i    : RV32I funct3 (size in [1:0], zero-extend in [2])
//   wdata_i     : store data as it came from rs2
//   rdata_lo_i  : read word of the first (or only) memory access
//   rdata_hi_i  : read word of the second access (split build only)
//   be_lo_o     : byte enables of the first access
//   wdata_lo_o  : lane-shifted store data of the first access
//   be_hi_o     : spilled byte enables of the second access (split build only)
//   wdata_hi_o  : spilled store data of the second access (split build only)
//   load_data_o : right-aligned, sign/zero-extended load result
// Build option: LSU_MISALIGNED_SPLIT_EN adds the second-access lanes and the
// high-word merge.
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
`ifdef LSU_MISALIGNED_SPLIT_EN
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_hi_o,
`endif
  output logic [3:0]  be_lo_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] load_data_o
);

  logic [4:0]  sh_lo;
  logic [31:0] shifted;
  logic        sign_ext;

  assign sh_lo      = {offset_i, 3'b000};
  assign be_lo_o    = be_mask(funct3_i[1:0]) << offset_i;
  assign wdata_lo_o = wdata_i << sh_lo;
  assign sign_ext   = ~funct3_i[2];

`ifdef LSU_MISALIGNED_SPLIT_EN
  // The second word carries whatever fell off the top of the first; at
  // offset 0 the shift is a full 32 bits and everything spilled is zero.
  logic [5:0] sh_hi;

  assign sh_hi      = 6'd32 - {1'b0, sh_lo};
  assign be_hi_o    = be_mask(funct3_i[1:0]) >> (3'd4 - {1'b0, offset_i});
  assign wdata_hi_o = wdata_i >> sh_hi;
  assign shifted    = (rdata_lo_i >> sh_lo) | (rdata_hi_i << sh_hi);
`else
  assign shifted    = rdata_lo_i >> sh_lo;
`endif

  always_comb begin
    load_data_o = shifted;
    case (funct3_i[1:0])
      SIZE_BYTE: load_data_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// ---------------------------------------------------------------------------
// lsu_split
// Load/store unit for the RV32I memory stage. Accepts one load or store at a
// time from execute, issues word-aligned byte-enabled accesses to a data
// memory of any latency, and returns extended load data or a store ack.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus.req_*    : request from execute (valid/ready, store, funct3, addr,
//                  wdata, rd)
//   bus.rsp_*    : one-cycle response pulse to writeback (rd, data, fault)
//   bus.mem_*    : data-memory request (valid/ready, we, addr, be, wdata) and
//                  response (valid, rdata)
// Build option: LSU_MISALIGNED_SPLIT_EN splits misaligned accesses into two
// aligned ones; without it they respond with a fault and never reach memory.
// ---------------------------------------------------------------------------
module lsu_split
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic        clock,
  input logic        reset,
  lsu_split_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              fault_q;
  logic [31:0]       lo_q;

  logic              capture;
  logic              lo_en;
  logic              req_bad;
  logic [3:0]        be_lo;
  logic [31:0]       wdata_lo;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] word_base;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [31:0]       hi_q;
  logic              hi_en;
  logic [3:0]        be_hi;
  logic [31:0]       wdata_hi;
`endif

  assign word_base = {addr_q[ADDR_W-1:2], 2'b00};

  // A request that can never touch memory goes straight to RESP as a fault.
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign req_bad = is_illegal(bus.req_store, bus.req_funct3);
`else
  assign req_bad = is_illegal(bus.req_store, bus.req_funct3) |
                   is_misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]);
`endif

  lsu_align u_align (
    .offset_i    (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q),
    .rdata_lo_i  (lo_q),
`ifdef LSU_MISALIGNED_SPLIT_EN
    .rdata_hi_i  (hi_q),
    .be_hi_o     (be_hi),
    .wdata_hi_o  (wdata_hi),
`endif
    .be_lo_o     (be_lo),
    .wdata_lo_o  (wdata_lo),
    .load_data_o (load_data)
  );

  // Next-state logic plus the load enables for the request and read-data
  // registers. Memory responses only count in the WAIT states, so a late
  // response left over from an aborted access is dropped in IDLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    lo_en   = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    hi_en   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          state_d = req_bad ? RESP : REQ0;
        end
      end
      REQ0: begin
        if (bus.mem_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        if (bus.mem_rsp_valid) begin
          lo_en = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
          state_d = split_q ? REQ1 : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      REQ1: begin
        if (bus.mem_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_rsp_valid) begin
          hi_en   = 1'b1;
          state_d = RESP;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and the captured request. The request fields are held for
  // the whole transaction so the memory-side outputs stay stable under stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      lo_q     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q  <= 1'b0;
      hi_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        store_q  <= bus.req_store;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rd_q     <= bus.req_rd;
        fault_q  <= req_bad;
`ifdef LSU_MISALIGNED_SPLIT_EN
        split_q  <= is_misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]);
`endif
      end
      if (lo_en) lo_q <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (hi_en) hi_q <= bus.mem_rdata;
`endif
    end
  end

  // Memory request outputs are zero outside the REQ states; the second
  // access targets the next word and wraps at the top of the address space.
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_be        = '0;
    bus.mem_wdata     = '0;
    case (state_q)
      REQ0: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = store_q;
        bus.mem_addr      = word_base;
        bus.mem_be        = be_lo;
        bus.mem_wdata     = store_q ? wdata_lo : '0;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      REQ1: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = store_q;
        bus.mem_addr      = word_base + ADDR_W'(4);
        bus.mem_be        = be_hi;
        bus.mem_wdata     = store_q ? wdata_hi : '0;
      end
`endif
      default: ;
    endcase
  end

  // Response is a single-cycle pulse; data is zero for stores and faults.
  assign bus.req_ready = (state_q == IDLE) & ~reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rd    = (state_q == RESP) ? rd_q : '0;
  assign bus.rsp_fault = (state_q == RESP) & fault_q;
  assign bus.rsp_data  = ((state_q == RESP) && !store_q && !fault_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_split.sv
// ---------------------------------------------------------------------------
// tb_lsu_split
// Directed bench for lsu_split with a small latency-configurable data memory.
// Build option: LSU_MISALIGNED_SPLIT_EN selects split or fault expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_split;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  // Memory model configuration and transaction log
  int          lat_cfg = 1;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] hold_addr = '0;
  logic [3:0]  hold_be = '0;
  int          txn_count = 0;
  int          mem_rsp_seen = 0;
  logic [31:0] txn_addr [4];
  logic [3:0]  txn_be [4];
  logic        txn_we [4];
  logic [31:0] txn_wdata [4];

  always #5 clock = ~clock;

  lsu_split_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_split #(.ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h8765_4321;
      32'h0000_1004: return 32'h0000_00AA;
      32'h0000_0000: return 32'h1122_3344;
      32'hFFFF_FFFC: return 32'hCAFE_BABE;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Data memory: decides ready and response on the falling edge. A response
  // with latency L arrives on the L-th falling edge after the handshake.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = '0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rdata     = mem_word(pend_addr);
          mem_rsp_seen++;
        end
      end
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        if (stall_left > 0) begin
          if (stall_seen == 0) begin
            hold_addr = bus.mem_addr;
            hold_be   = bus.mem_be;
          end else if (bus.mem_addr !== hold_addr || bus.mem_be !== hold_be) begin
            stall_bad++;
          end
          stall_seen++;
          stall_left--;
        end else begin
          if (stall_seen > 0 && (bus.mem_addr !== hold_addr || bus.mem_be !== hold_be))
            stall_bad++;
          bus.mem_req_ready = 1'b1;
          if (txn_count < 4) begin
            txn_addr[txn_count]  = bus.mem_addr;
            txn_be[txn_count]    = bus.mem_be;
            txn_we[txn_count]    = bus.mem_we;
            txn_wdata[txn_count] = bus.mem_wdata;
          end
          txn_count++;
          pend_cnt  = lat_cfg;
          pend_addr = bus.mem_addr;
        end
      end else if (stall_seen > 0 && stall_left > 0) begin
        stall_bad++;
      end
    end
  end

  // Global time bound in case the DUT locks up outside a bounded wait
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Issue one request and watch up to 60 cycles for its response.
  // rsp_k is the cycle of the first rsp_valid counted from the handshake
  // (0 if none came); ready_hi counts req_ready high up to and including it.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd,
                               output int rsp_k, output logic [31:0] data, output logic flt,
                               output logic [4:0] rdo, output int pulses, output int ready_hi,
                               output logic ready_after);
    rsp_k = 0; data = '0; flt = 1'b0; rdo = '0; pulses = 0; ready_hi = 0; ready_after = 1'b0;
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.rsp_valid) begin
        pulses++;
        if (rsp_k == 0) begin
          rsp_k = k;
          data  = bus.rsp_data;
          flt   = bus.rsp_fault;
          rdo   = bus.rsp_rd;
        end
      end
      if ((rsp_k == 0 || rsp_k == k) && bus.req_ready) ready_hi++;
      if (rsp_k != 0 && k == rsp_k + 1) ready_after = bus.req_ready;
      if (rsp_k != 0 && k >= rsp_k + 3) break;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    compared++;
    if (bus.req_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0", bus.req_ready);
    end
    compared++;
    if ({bus.rsp_valid, bus.rsp_fault, bus.mem_req_valid, bus.mem_we} !== 4'b0) begin
      mismatched++; $display("[TB] FAIL reset_ctrl: got %b expected 0000",
                             {bus.rsp_valid, bus.rsp_fault, bus.mem_req_valid, bus.mem_we});
    end
    compared++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rsp_data, bus.rsp_rd} !== '0) begin
      mismatched++; $display("[TB] FAIL reset_data: addr %h be %b wdata %h rdata %h rd %0d expected all 0",
                             bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rsp_data, bus.rsp_rd);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (bus.req_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL post_reset_req_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] va [6];
    logic [2:0]  vf [6];
    logic [31:0] ve [6];
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    va[0] = 32'h1001; vf[0] = F3_LB;  ve[0] = 32'h0000_0043;
    va[1] = 32'h1003; vf[1] = F3_LB;  ve[1] = 32'hFFFF_FF87;
    va[2] = 32'h1003; vf[2] = F3_LBU; ve[2] = 32'h0000_0087;
    va[3] = 32'h1002; vf[3] = F3_LH;  ve[3] = 32'hFFFF_8765;
    va[4] = 32'h1000; vf[4] = F3_LW;  ve[4] = 32'h8765_4321;
    va[5] = 32'h1000; vf[5] = F3_LHU; ve[5] = 32'h0000_4321;
    for (int i = 0; i < 6; i++) begin
      lat_cfg = 1; stall_left = 0; stall_seen = 0; txn_count = 0;
      applyStimulus(1'b0, vf[i], va[i], 32'h0, 5'(i + 1), k, d, f, r, p, rh, ra);
      compared++;
      if (d !== ve[i]) begin
        mismatched++; $display("[TB] FAIL load_data[%0d]: got %h expected %h", i, d, ve[i]);
      end
      compared++;
      if (k !== 3) begin
        mismatched++; $display("[TB] FAIL load_latency[%0d]: got %0d expected 3", i, k);
      end
      compared++;
      if ({f, r} !== {1'b0, 5'(i + 1)}) begin
        mismatched++; $display("[TB] FAIL load_fault_rd[%0d]: got %b/%0d expected 0/%0d", i, f, r, i + 1);
      end
      compared++;
      if (txn_count !== 1 || txn_addr[0] !== 32'h1000 || txn_we[0] !== 1'b0) begin
        mismatched++; $display("[TB] FAIL load_txn[%0d]: got count %0d addr %h we %b expected 1 00001000 0",
                               i, txn_count, txn_addr[0], txn_we[0]);
      end
    end
  endtask

  task automatic test_stores();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    lat_cfg = 1; stall_left = 0; stall_seen = 0; txn_count = 0;
    applyStimulus(1'b1, F3_SH, 32'h1002, 32'h0000_BEEF, 5'd0, k, d, f, r, p, rh, ra);
    compared++;
    if (txn_addr[0] !== 32'h1000 || txn_be[0] !== 4'b1100 || txn_we[0] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL sh_txn: got addr %h be %b we %b expected 00001000 1100 1",
                             txn_addr[0], txn_be[0], txn_we[0]);
    end
    compared++;
    if (txn_wdata[0] !== 32'hBEEF_0000) begin
      mismatched++; $display("[TB] FAIL sh_wdata: got %h expected beef0000", txn_wdata[0]);
    end
    compared++;
    if (k !== 3 || d !== 32'h0 || f !== 1'b0) begin
      mismatched++; $display("[TB] FAIL sh_rsp: got cycle %0d data %h fault %b expected 3 0 0", k, d, f);
    end
    lat_cfg = 1; txn_count = 0;
    applyStimulus(1'b1, F3_SB, 32'h1001, 32'h0000_00A5, 5'd0, k, d, f, r, p, rh, ra);
    compared++;
    if (txn_be[0] !== 4'b0010 || txn_wdata[0] !== 32'h0000_A500 || txn_count !== 1) begin
      mismatched++; $display("[TB] FAIL sb_txn: got be %b wdata %h count %0d expected 0010 0000a500 1",
                             txn_be[0], txn_wdata[0], txn_count);
    end
  endtask

  task automatic test_stall();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    lat_cfg = 4; stall_left = 3; stall_seen = 0; stall_bad = 0; txn_count = 0;
    applyStimulus(1'b0, F3_LW, 32'h1000, 32'h0, 5'd7, k, d, f, r, p, rh, ra);
    compared++;
    if (stall_seen !== 3 || stall_bad !== 0) begin
      mismatched++; $display("[TB] FAIL stall_stable: got stalled %0d unstable %0d expected 3 0",
                             stall_seen, stall_bad);
    end
    compared++;
    if (k !== 9 || d !== 32'h8765_4321 || r !== 5'd7) begin
      mismatched++; $display("[TB] FAIL stall_rsp: got cycle %0d data %h rd %0d expected 9 87654321 7", k, d, r);
    end
    compared++;
    if (p !== 1 || txn_count !== 1) begin
      mismatched++; $display("[TB] FAIL stall_pulses: got rsp %0d txn %0d expected 1 1", p, txn_count);
    end
    compared++;
    if (rh !== 0 || ra !== 1'b1) begin
      mismatched++; $display("[TB] FAIL stall_req_ready: got high %0d after %b expected 0 1", rh, ra);
    end
    stall_seen = 0;
  endtask

  task automatic test_misaligned();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    lat_cfg = 1; stall_left = 0; txn_count = 0;
    applyStimulus(1'b0, F3_LW, 32'h1003, 32'h0, 5'd9, k, d, f, r, p, rh, ra);
`ifdef LSU_MISALIGNED_SPLIT_EN
    compared++;
    if (k !== 5 || d !== 32'h0000_AA87 || f !== 1'b0) begin
      mismatched++; $display("[TB] FAIL split_lw: got cycle %0d data %h fault %b expected 5 0000aa87 0", k, d, f);
    end
    compared++;
    if (txn_count !== 2 || txn_addr[0] !== 32'h1000 || txn_be[0] !== 4'b1000 ||
        txn_addr[1] !== 32'h1004 || txn_be[1] !== 4'b0111) begin
      mismatched++; $display("[TB] FAIL split_lw_txn: got %0d %h/%b %h/%b expected 2 00001000/1000 00001004/0111",
                             txn_count, txn_addr[0], txn_be[0], txn_addr[1], txn_be[1]);
    end
`else
    compared++;
    if (k !== 1 || f !== 1'b1 || d !== 32'h0 || r !== 5'd9 || txn_count !== 0) begin
      mismatched++; $display("[TB] FAIL misaligned_fault: got cycle %0d fault %b data %h rd %0d txn %0d expected 1 1 0 9 0",
                             k, f, d, r, txn_count);
    end
`endif
    lat_cfg = 1; txn_count = 0;
    applyStimulus(1'b0, F3_LH, 32'h1003, 32'h0, 5'd10, k, d, f, r, p, rh, ra);
`ifdef LSU_MISALIGNED_SPLIT_EN
    compared++;
    if (k !== 5 || d !== 32'hFFFF_AA87 || txn_be[1] !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL split_lh: got cycle %0d data %h be1 %b expected 5 ffffaa87 0001", k, d, txn_be[1]);
    end
`else
    compared++;
    if (k !== 1 || f !== 1'b1 || txn_count !== 0) begin
      mismatched++; $display("[TB] FAIL misaligned_lh_fault: got cycle %0d fault %b txn %0d expected 1 1 0", k, f, txn_count);
    end
`endif
    lat_cfg = 1; txn_count = 0;
    applyStimulus(1'b1, F3_SW, 32'h1001, 32'h1122_3344, 5'd0, k, d, f, r, p, rh, ra);
`ifdef LSU_MISALIGNED_SPLIT_EN
    compared++;
    if (txn_count !== 2 || txn_be[0] !== 4'b1110 || txn_wdata[0] !== 32'h2233_4400 ||
        txn_addr[1] !== 32'h1004 || txn_be[1] !== 4'b0001 || txn_wdata[1] !== 32'h0000_0011) begin
      mismatched++; $display("[TB] FAIL split_sw_txn: got %0d %b/%h %h/%b/%h expected 2 1110/22334400 00001004/0001/00000011",
                             txn_count, txn_be[0], txn_wdata[0], txn_addr[1], txn_be[1], txn_wdata[1]);
    end
    compared++;
    if (k !== 5 || d !== 32'h0) begin
      mismatched++; $display("[TB] FAIL split_sw_rsp: got cycle %0d data %h expected 5 0", k, d);
    end
`else
    compared++;
    if (k !== 1 || f !== 1'b1 || txn_count !== 0) begin
      mismatched++; $display("[TB] FAIL misaligned_sw_fault: got cycle %0d fault %b txn %0d expected 1 1 0", k, f, txn_count);
    end
`endif
  endtask

  task automatic test_wrap();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    lat_cfg = 1; stall_left = 0; txn_count = 0;
    applyStimulus(1'b0, F3_LW, 32'hFFFF_FFFE, 32'h0, 5'd11, k, d, f, r, p, rh, ra);
`ifdef LSU_MISALIGNED_SPLIT_EN
    compared++;
    if (txn_addr[0] !== 32'hFFFF_FFFC || txn_be[0] !== 4'b1100 ||
        txn_addr[1] !== 32'h0000_0000 || txn_be[1] !== 4'b0011) begin
      mismatched++; $display("[TB] FAIL wrap_txn: got %h/%b %h/%b expected fffffffc/1100 00000000/0011",
                             txn_addr[0], txn_be[0], txn_addr[1], txn_be[1]);
    end
    compared++;
    if (d !== 32'h3344_CAFE) begin
      mismatched++; $display("[TB] FAIL wrap_data: got %h expected 3344cafe", d);
    end
`else
    compared++;
    if (k !== 1 || f !== 1'b1 || txn_count !== 0) begin
      mismatched++; $display("[TB] FAIL wrap_fault: got cycle %0d fault %b txn %0d expected 1 1 0", k, f, txn_count);
    end
`endif
  endtask

  task automatic test_illegal();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    logic       vs [3];
    logic [2:0] vf [3];
    vs[0] = 1'b0; vf[0] = 3'd3;
    vs[1] = 1'b0; vf[1] = 3'd6;
    vs[2] = 1'b1; vf[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      lat_cfg = 1; stall_left = 0; txn_count = 0;
      applyStimulus(vs[i], vf[i], 32'h1000, 32'h1234_5678, 5'd12, k, d, f, r, p, rh, ra);
      compared++;
      if (k !== 1 || f !== 1'b1 || d !== 32'h0 || r !== 5'd12) begin
        mismatched++; $display("[TB] FAIL illegal_rsp[%0d]: got cycle %0d fault %b data %h rd %0d expected 1 1 0 12",
                               i, k, f, d, r);
      end
      compared++;
      if (txn_count !== 0 || p !== 1) begin
        mismatched++; $display("[TB] FAIL illegal_txn[%0d]: got txn %0d rsp %0d expected 0 1", i, txn_count, p);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, p, rh; logic [31:0] d; logic f, ra; logic [4:0] r;
    int bad_out, rsp_cnt, ready_lo, rsp_before;
    bad_out = 0; rsp_cnt = 0; ready_lo = 0;
    lat_cfg = 3; stall_left = 0; txn_count = 0;
    rsp_before = mem_rsp_seen;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_LW;
    bus.req_addr = 32'h1000; bus.req_wdata = '0; bus.req_rd = 5'd3;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rd = '0; bus.req_funct3 = '0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    compared++;
    if (bus.req_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mid_reset_outputs: got ready %b memvalid %b expected 0 0",
                             bus.req_ready, bus.mem_req_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) rsp_cnt++;
      if (!bus.req_ready) ready_lo++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_be, bus.rsp_data, bus.rsp_fault} !== '0) bad_out++;
    end
    compared++;
    if (rsp_cnt !== 0 || bad_out !== 0 || ready_lo !== 0) begin
      mismatched++; $display("[TB] FAIL mid_reset_idle: got rsp %0d nonzero %0d notready %0d expected 0 0 0",
                             rsp_cnt, bad_out, ready_lo);
    end
    compared++;
    if (mem_rsp_seen - rsp_before !== 1) begin
      mismatched++; $display("[TB] FAIL mid_reset_late_rsp: got %0d memory responses expected 1", mem_rsp_seen - rsp_before);
    end
    lat_cfg = 1; txn_count = 0;
    applyStimulus(1'b0, F3_LB, 32'h1001, 32'h0, 5'd4, k, d, f, r, p, rh, ra);
    compared++;
    if (k !== 3 || d !== 32'h0000_0043 || r !== 5'd4 || p !== 1) begin
      mismatched++; $display("[TB] FAIL after_reset_load: got cycle %0d data %h rd %0d rsp %0d expected 3 00000043 4 1",
                             k, d, r, p);
    end
  endtask

  task automatic checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    $display("[TB] tb_lsu_split start");
    test_reset();
    test_loads();
    test_stores();
    test_stall();
    test_misaligned();
    test_wrap();
    test_illegal();
    test_reset_mid();
    checkOutput();
    $finish;
  end

endmodule
